// File: rtl/fp_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_issue_ctrl_pkg
// Brief  : FPU operation encodings, issue-FSM state type and canonical NaN.
// Rev    : 1.0
// ============================================================================
package fp_issue_ctrl_pkg;

    localparam logic [2:0] C_FPU_ADD  = 3'b000;
    localparam logic [2:0] C_FPU_SUB  = 3'b001;
    localparam logic [2:0] C_FPU_MUL  = 3'b010;
    localparam logic [2:0] C_FPU_DIV  = 3'b011;
    localparam logic [2:0] C_FPU_SGNJ = 3'b100;

    localparam logic [31:0] C_CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fp_state_t;

    function automatic logic is_illegal_ctrl(input logic [2:0] ctrl);
        return (ctrl > C_FPU_SGNJ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_regfile.sv
`default_nettype none
// ============================================================================
// Module : fp_regfile
// Brief  : 32x32 FP register file, two async read ports, WB write beats load.
// Rev    : 1.0
// ============================================================================
module fp_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_ld_we,
    input  logic [4:0]  i_ld_addr,
    input  logic [31:0] i_ld_data
);

    logic [31:0] r_mem [32];
    logic        w_ld_drop;

    assign w_ld_drop = i_wb_we && (i_wb_addr == i_ld_addr);
    assign o_rd1     = r_mem[i_ra1];
    assign o_rd2     = r_mem[i_ra2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_ld_we && !w_ld_drop) begin
                r_mem[i_ld_addr] <= i_ld_data;
            end
            if (i_wb_we) begin
                r_mem[i_wb_addr] <= i_wb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fp_issue_ctrl
// Brief  : Single-issue FP controller: operand fetch, timed FPU hold, writeback.
// Rev    : 1.0
// ============================================================================
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int LAT_ADDSUB = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  req_fpu_control,
    input  logic [2:0]  req_funct3,
    output logic [31:0] fpu_rs1,
    output logic [31:0] fpu_rs2,
    output logic [2:0]  fpu_control,
    output logic [2:0]  fpu_funct3,
    output logic        fpu_sel,
    input  logic [31:0] fpu_result,
    input  logic        ld_we,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        illegal
);

    localparam int C_LAT_MAX = (LAT_DIV > LAT_MUL)
                             ? ((LAT_DIV > LAT_ADDSUB) ? LAT_DIV : LAT_ADDSUB)
                             : ((LAT_MUL > LAT_ADDSUB) ? LAT_MUL : LAT_ADDSUB);
    localparam int C_CNT_W   = (C_LAT_MAX > 1) ? $clog2(C_LAT_MAX) : 1;

    fp_state_t           r_state;
    fp_state_t           w_state_nxt;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_CNT_W-1:0]  w_lat_m1;
    logic [31:0]         r_op1;
    logic [31:0]         r_op2;
    logic [2:0]          r_ctrl;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic [4:0]          r_wb_rd;
    logic [31:0]         r_wb_data;
    logic                r_wb_illegal;
    logic [31:0]         w_rf_rd1;
    logic [31:0]         w_rf_rd2;
    logic [31:0]         w_op1;
    logic [31:0]         w_op2;
    logic                w_accept;
    logic                w_exec_done;
    logic                w_illegal;

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = !req_ready;
    assign wb_valid    = (r_state == ST_WB);
    assign illegal     = wb_valid && r_wb_illegal;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign fpu_rs1     = r_op1;
    assign fpu_rs2     = r_op2;
    assign fpu_control = r_ctrl;
    assign fpu_funct3  = r_funct3;
    assign fpu_sel     = (r_ctrl == C_FPU_SUB);

    assign w_accept    = req_ready && req_valid;
    assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == '0);
    assign w_illegal   = is_illegal_ctrl(r_ctrl);

    // A load landing in the accept cycle is forwarded straight into the operands.
    assign w_op1 = (ld_we && (ld_addr == req_rs1)) ? ld_data : w_rf_rd1;
    assign w_op2 = (ld_we && (ld_addr == req_rs2)) ? ld_data : w_rf_rd2;

    always_comb begin
        w_lat_m1 = '0;
        case (req_fpu_control)
            C_FPU_ADD, C_FPU_SUB: w_lat_m1 = C_CNT_W'(LAT_ADDSUB - 1);
            C_FPU_MUL:            w_lat_m1 = C_CNT_W'(LAT_MUL - 1);
            C_FPU_DIV:            w_lat_m1 = C_CNT_W'(LAT_DIV - 1);
            default:              w_lat_m1 = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)   w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == '0) w_state_nxt = ST_WB;
            ST_WB:                    w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_ctrl       <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_wb_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1    <= w_op1;
                r_op2    <= w_op2;
                r_ctrl   <= req_fpu_control;
                r_funct3 <= req_funct3;
                r_rd     <= req_rd;
                r_cnt    <= w_lat_m1;
            end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_exec_done) begin
                r_wb_rd      <= r_rd;
                r_wb_data    <= w_illegal ? C_CANON_NAN : fpu_result;
                r_wb_illegal <= w_illegal;
            end
        end
    end

    fp_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_ra1     (req_rs1),
        .i_ra2     (req_rs2),
        .o_rd1     (w_rf_rd1),
        .o_rd2     (w_rf_rd2),
        .i_wb_we   (wb_valid),
        .i_wb_addr (r_wb_rd),
        .i_wb_data (r_wb_data),
        .i_ld_we   (ld_we),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data)
    );

endmodule
`default_nettype wire
